// File: rtl/snd_mixer_pkg.sv
// ----------------------------------------------------------------------------
// snd_mixer_pkg
// Shared types and helpers for the N-channel stereo mixer.
//   mix_state_t  : frame sequencer states
//   UNITY_GAIN   : reset/default gain code for the default GFRAC (0x40)
//   sat_ow()     : clamp a wide signed value to a signed range of 'ow' bits
// Optional feature macro used by the mixer: SND_MIXER_DCBLOCK_EN
// ----------------------------------------------------------------------------
package snd_mixer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_MAC,
        ST_SCALE,
        ST_FILT,
        ST_OUT
    } mix_state_t;

    localparam int GFRAC_DEFAULT = 6;
    localparam int UNITY_GAIN    = 1 << GFRAC_DEFAULT;

    // Generic signed saturation; the caller truncates the result to 'ow' bits.
    function automatic logic signed [63:0] sat_ow(input logic signed [63:0] v,
                                                 input int                 ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/snd_mixer_nch_if.sv
// ----------------------------------------------------------------------------
// snd_mixer_nch_if
// Sample, register-bus and status signals of the mixer.
//   i_SAMPLE_CEN   frame start strobe (1 clock wide)
//   i_CH_DATA      packed signed samples, ch0 in the LSBs
//   i_REG_WR/ADDR/DATA  gain write port, ADDR = {channel, side}, side 0=L 1=R
//   o_SND_L/R      registered signed mix
//   o_SAMPLE_VALID / o_CLIP / o_OVERRUN  one-cycle pulses
//   o_BUSY         frame in progress
// Modports: master (sound CPU / sources side), slave (mixer).
// ----------------------------------------------------------------------------
interface snd_mixer_nch_if #(
    parameter int NCH = 4,
    parameter int IW  = 16,
    parameter int GW  = 8,
    parameter int OW  = 16
);
    localparam int AW = $clog2(NCH) + 1;

    logic                  i_SAMPLE_CEN;
    logic [NCH*IW-1:0]     i_CH_DATA;
    logic                  i_REG_WR;
    logic [AW-1:0]         i_REG_ADDR;
    logic [GW-1:0]         i_REG_DATA;
    logic signed [OW-1:0]  o_SND_L;
    logic signed [OW-1:0]  o_SND_R;
    logic                  o_SAMPLE_VALID;
    logic                  o_CLIP;
    logic                  o_OVERRUN;
    logic                  o_BUSY;

    modport master (
        output i_SAMPLE_CEN, i_CH_DATA, i_REG_WR, i_REG_ADDR, i_REG_DATA,
        input  o_SND_L, o_SND_R, o_SAMPLE_VALID, o_CLIP, o_OVERRUN, o_BUSY
    );

    modport slave (
        input  i_SAMPLE_CEN, i_CH_DATA, i_REG_WR, i_REG_ADDR, i_REG_DATA,
        output o_SND_L, o_SND_R, o_SAMPLE_VALID, o_CLIP, o_OVERRUN, o_BUSY
    );

endinterface

// File: rtl/snd_mixer_dcblock.sv
// ----------------------------------------------------------------------------
// snd_mixer_dcblock
// One-pole DC blocker for one output side:
//   y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> DCK)
// State kept at OW+2 bits, output re-saturated to OW bits and registered.
// Ports: mclk, rst (async, active high), en (advance one sample), x (input
// sample), y (registered output), clip (output re-saturation happened).
// Instantiated only when SND_MIXER_DCBLOCK_EN is defined.
// ----------------------------------------------------------------------------
module snd_mixer_dcblock
    import snd_mixer_pkg::*;
#(
    parameter int OW  = 16,
    parameter int DCK = 8
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [OW-1:0] x,
    output logic signed [OW-1:0] y,
    output logic                 clip
);
    localparam int SW = OW + 2;

    logic signed [SW-1:0] x_d;
    logic signed [SW-1:0] y_d;
    logic signed [63:0]   y_w;
    logic signed [63:0]   y_st;
    logic signed [63:0]   y_o;

    assign y_w  = 64'(x) - 64'(x_d) + 64'(y_d) - 64'(y_d >>> DCK);
    assign y_st = sat_ow(y_w, SW);
    assign y_o  = sat_ow(y_st, OW);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            x_d  <= '0;
            y_d  <= '0;
            y    <= '0;
            clip <= 1'b0;
        end else if (en) begin
            x_d  <= SW'(x);
            y_d  <= SW'(y_st);
            y    <= OW'(y_o);
            clip <= (y_o != y_st);
        end
    end

endmodule

// File: rtl/snd_mixer_nch.sv
// ----------------------------------------------------------------------------
// snd_mixer_nch
// N-channel stereo mixer: per-channel L/R gain, one multiplier per side
// time-multiplexed over the channels, arithmetic scale and output saturation.
// Ports:
//   i_EMU_MCLK  master clock, all logic on posedge
//   i_EMU_RST   asynchronous active-high reset
//   bus         snd_mixer_nch_if.slave (samples, gain writes, outputs/status)
// Optional feature: define SND_MIXER_DCBLOCK_EN to add a DC blocker per side
// after saturation (one extra cycle of latency).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting; a strobe here snapshots samples and copies the gains
// LATCH    | one bubble so the MAC starts from the registered snapshot
// MAC      | NCH cycles, channel k accumulated into both sides
// SCALE    | shift by GFRAC, saturate; result registered on leaving
// FILT     | DC blocker output settles (SND_MIXER_DCBLOCK_EN only)
// OUT      | outputs valid, VALID/CLIP high; strobes here are dropped
// ----------------------------------------------------------------------------
module snd_mixer_nch
    import snd_mixer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int IW    = 16,
    parameter int GW    = 8,
    parameter int GFRAC = GFRAC_DEFAULT,
    parameter int OW    = 16,
    parameter int DCK   = 8
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_RST,
    snd_mixer_nch_if.slave bus
);
    localparam int AW   = $clog2(NCH) + 1;
    localparam int CW   = $clog2(NCH);
    localparam int ACCW = IW + GW + $clog2(NCH) + 1;
    localparam int PW   = IW + GW + 1;
    localparam logic [GW-1:0] UNITY = GW'(1 << GFRAC);

    mix_state_t state, state_nx;

    logic [CW-1:0]        k;
    logic [GW-1:0]        pend_l [NCH];
    logic [GW-1:0]        pend_r [NCH];
    logic [GW-1:0]        act_l  [NCH];
    logic [GW-1:0]        act_r  [NCH];
    logic signed [IW-1:0] x_snap [NCH];
    logic signed [ACCW-1:0] acc_l, acc_r;

    logic signed [OW-1:0] snd_l, snd_r;
    logic                 valid_q, clip_q, overrun_q, busy_q;

    logic [CW-1:0]        wr_ch;
    logic                 wr_ok;
    logic signed [PW-1:0] prod_l, prod_r;
    logic signed [63:0]   sh_l, sh_r, sat_l, sat_r;
    logic                 sat_hit;

    assign wr_ch = bus.i_REG_ADDR[AW-1:1];
    assign wr_ok = bus.i_REG_WR && (int'(wr_ch) < NCH);

    // Gain is unsigned: zero-extend before the signed multiply.
    assign prod_l = x_snap[k] * $signed({1'b0, act_l[k]});
    assign prod_r = x_snap[k] * $signed({1'b0, act_r[k]});

    assign sh_l    = 64'(acc_l >>> GFRAC);
    assign sh_r    = 64'(acc_r >>> GFRAC);
    assign sat_l   = sat_ow(sh_l, OW);
    assign sat_r   = sat_ow(sh_r, OW);
    assign sat_hit = (sat_l != sh_l) || (sat_r != sh_r);

`ifdef SND_MIXER_DCBLOCK_EN
    logic signed [OW-1:0] dc_l, dc_r;
    logic                 dc_clip_l, dc_clip_r;
    logic                 clip_pend;

    snd_mixer_dcblock #(.OW(OW), .DCK(DCK)) u_dc_l (
        .mclk (i_EMU_MCLK),
        .rst  (i_EMU_RST),
        .en   (state == ST_SCALE),
        .x    (OW'(sat_l)),
        .y    (dc_l),
        .clip (dc_clip_l)
    );

    snd_mixer_dcblock #(.OW(OW), .DCK(DCK)) u_dc_r (
        .mclk (i_EMU_MCLK),
        .rst  (i_EMU_RST),
        .en   (state == ST_SCALE),
        .x    (OW'(sat_r)),
        .y    (dc_r),
        .clip (dc_clip_r)
    );
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (bus.i_SAMPLE_CEN) state_nx = ST_LATCH;
            ST_LATCH: state_nx = ST_MAC;
            ST_MAC:   if (k == CW'(NCH - 1)) state_nx = ST_SCALE;
`ifdef SND_MIXER_DCBLOCK_EN
            ST_SCALE: state_nx = ST_FILT;
`else
            ST_SCALE: state_nx = ST_OUT;
`endif
            ST_FILT:  state_nx = ST_OUT;
            ST_OUT:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
        if (i_EMU_RST) begin
            state     <= ST_IDLE;
            k         <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            snd_l     <= '0;
            snd_r     <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SND_MIXER_DCBLOCK_EN
            clip_pend <= 1'b0;
`endif
            for (int i = 0; i < NCH; i++) begin
                pend_l[i] <= UNITY;
                pend_r[i] <= UNITY;
                act_l[i]  <= UNITY;
                act_r[i]  <= UNITY;
                x_snap[i] <= '0;
            end
        end else begin
            state     <= state_nx;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= bus.i_SAMPLE_CEN && (state != ST_IDLE);
            busy_q    <= (state_nx == ST_LATCH) || (state_nx == ST_MAC) ||
                         (state_nx == ST_SCALE) || (state_nx == ST_FILT);

            // Pending bank is always writable; the active copy below reads
            // the pre-edge pending value, so a coincident write waits a frame.
            if (wr_ok) begin
                if (bus.i_REG_ADDR[0])
                    pend_r[wr_ch] <= bus.i_REG_DATA;
                else
                    pend_l[wr_ch] <= bus.i_REG_DATA;
            end

            unique case (state)
                ST_IDLE: begin
                    if (bus.i_SAMPLE_CEN) begin
                        for (int i = 0; i < NCH; i++) begin
                            x_snap[i] <= $signed(bus.i_CH_DATA[i*IW +: IW]);
                            act_l[i]  <= pend_l[i];
                            act_r[i]  <= pend_r[i];
                        end
                        acc_l <= '0;
                        acc_r <= '0;
                        k     <= '0;
                    end
                end
                ST_MAC: begin
                    acc_l <= acc_l + ACCW'(prod_l);
                    acc_r <= acc_r + ACCW'(prod_r);
                    k     <= k + 1'b1;
                end
                ST_SCALE: begin
`ifdef SND_MIXER_DCBLOCK_EN
                    clip_pend <= sat_hit;
`else
                    snd_l   <= OW'(sat_l);
                    snd_r   <= OW'(sat_r);
                    valid_q <= 1'b1;
                    clip_q  <= sat_hit;
`endif
                end
`ifdef SND_MIXER_DCBLOCK_EN
                ST_FILT: begin
                    snd_l   <= dc_l;
                    snd_r   <= dc_r;
                    valid_q <= 1'b1;
                    clip_q  <= clip_pend || dc_clip_l || dc_clip_r;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.o_SND_L        = snd_l;
    assign bus.o_SND_R        = snd_r;
    assign bus.o_SAMPLE_VALID = valid_q;
    assign bus.o_CLIP         = clip_q;
    assign bus.o_OVERRUN      = overrun_q;
    assign bus.o_BUSY         = busy_q;

endmodule

// File: tb/tb_snd_mixer_nch.sv
// ----------------------------------------------------------------------------
// tb_snd_mixer_nch
// Directed and randomized frames for snd_mixer_nch, checked against a
// behavioural mix model (sum of sample*gain, floor-scaled, clamped).
// Honours SND_MIXER_DCBLOCK_EN for latency and the DC blocker model.
// ----------------------------------------------------------------------------
module tb_snd_mixer_nch;
    import snd_mixer_pkg::*;

    localparam int NCH   = 4;
    localparam int IW    = 16;
    localparam int GW    = 8;
    localparam int GFRAC = 6;
    localparam int OW    = 16;
    localparam int DCK   = 8;
    localparam int AW    = $clog2(NCH) + 1;
`ifdef SND_MIXER_DCBLOCK_EN
    localparam int LAT = NCH + 3;
`else
    localparam int LAT = NCH + 2;
`endif

    logic mclk = 1'b0;
    logic rst  = 1'b1;

    snd_mixer_nch_if #(.NCH(NCH), .IW(IW), .GW(GW), .OW(OW)) bus ();

    snd_mixer_nch #(
        .NCH(NCH), .IW(IW), .GW(GW), .GFRAC(GFRAC), .OW(OW), .DCK(DCK)
    ) dut (
        .i_EMU_MCLK (mclk),
        .i_EMU_RST  (rst),
        .bus        (bus)
    );

    always #5 mclk = ~mclk;

    int     checks = 0;
    int     errors = 0;
    int     gain_pend [NCH][2];
    int     gain_act  [NCH][2];
    int     xs        [NCH];
    longint exp_l, exp_r;
    logic   exp_clip;
    longint dc_x [2];
    longint dc_y [2];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint clamp(input longint v, input int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            gain_pend[ch][0] = UNITY_GAIN;
            gain_pend[ch][1] = UNITY_GAIN;
        end
        dc_x[0] = 0; dc_x[1] = 0; dc_y[0] = 0; dc_y[1] = 0;
    endtask

    task automatic model_frame();
        longint s, v, q;
        exp_clip = 1'b0;
        for (int sd = 0; sd < 2; sd++) begin
            s = 0;
            for (int ch = 0; ch < NCH; ch++)
                s += longint'(xs[ch]) * gain_act[ch][sd];
            v = s >>> GFRAC;
            q = clamp(v, OW);
            if (q != v) exp_clip = 1'b1;
`ifdef SND_MIXER_DCBLOCK_EN
            v = q - dc_x[sd] + dc_y[sd] - (dc_y[sd] >>> DCK);
            dc_x[sd] = q;
            dc_y[sd] = clamp(v, OW + 2);
            q = clamp(dc_y[sd], OW);
            if (q != dc_y[sd]) exp_clip = 1'b1;
`endif
            if (sd == 0) exp_l = q; else exp_r = q;
        end
    endtask

    task automatic write_gain(input int ch, input int side, input int val);
        @(negedge mclk);
        bus.i_REG_WR   = 1'b1;
        bus.i_REG_ADDR = AW'((ch << 1) | side);
        bus.i_REG_DATA = GW'(val);
        @(negedge mclk);
        bus.i_REG_WR = 1'b0;
        gain_pend[ch][side] = val;
    endtask

    // One frame. second_at: cycle of a second strobe (0 = none);
    // strobe_at_out: strobe during the VALID cycle; wr_at: gain write cycle
    // (-1 none, 0 coincident with the accepted strobe).
    task automatic frame(input string tag, input int second_at, input bit strobe_at_out,
                         input int wr_at, input int wr_ch, input int wr_side, input int wr_val);
        int lat, nover, nextra;
        lat = 0; nover = 0; nextra = 0;
        @(negedge mclk);
        for (int ch = 0; ch < NCH; ch++)
            bus.i_CH_DATA[ch*IW +: IW] = IW'(xs[ch]);
        bus.i_REG_ADDR   = AW'((wr_ch << 1) | wr_side);
        bus.i_REG_DATA   = GW'(wr_val);
        bus.i_REG_WR     = (wr_at == 0);
        bus.i_SAMPLE_CEN = 1'b1;
        gain_act = gain_pend;
        if (wr_at == 0) gain_pend[wr_ch][wr_side] = wr_val;
        model_frame();
        @(posedge mclk); #1;
        bus.i_SAMPLE_CEN = 1'b0;
        bus.i_REG_WR     = 1'b0;
        check({tag, "_busy_start"}, bus.o_BUSY, 1);
        for (int c = 1; c <= LAT + 4; c++) begin
            bus.i_SAMPLE_CEN = (second_at != 0) && (c == second_at);
            bus.i_REG_WR     = (wr_at > 0) && (c == wr_at);
            if ((wr_at > 0) && (c == wr_at)) gain_pend[wr_ch][wr_side] = wr_val;
            @(posedge mclk); #1;
            bus.i_SAMPLE_CEN = 1'b0;
            bus.i_REG_WR     = 1'b0;
            if (bus.o_OVERRUN) nover++;
            if (bus.o_SAMPLE_VALID) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_snd_l"}, $signed(bus.o_SND_L), exp_l);
        check({tag, "_snd_r"}, $signed(bus.o_SND_R), exp_r);
        check({tag, "_clip"}, bus.o_CLIP, exp_clip);
        check({tag, "_busy_end"}, bus.o_BUSY, 0);
        bus.i_SAMPLE_CEN = strobe_at_out;
        for (int c = 0; c < LAT + 3; c++) begin
            @(posedge mclk); #1;
            bus.i_SAMPLE_CEN = 1'b0;
            if (bus.o_OVERRUN) nover++;
            if (bus.o_SAMPLE_VALID) nextra++;
        end
        check({tag, "_overruns"}, nover, int'(second_at != 0) + int'(strobe_at_out));
        check({tag, "_extra_valid"}, nextra, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        bus.i_SAMPLE_CEN = 1'b0;
        bus.i_CH_DATA    = '0;
        bus.i_REG_WR     = 1'b0;
        bus.i_REG_ADDR   = '0;
        bus.i_REG_DATA   = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge mclk);
        #1;
        check("rst_snd_l", $signed(bus.o_SND_L), 0);
        check("rst_snd_r", $signed(bus.o_SND_R), 0);
        check("rst_valid", bus.o_SAMPLE_VALID, 0);
        check("rst_clip", bus.o_CLIP, 0);
        check("rst_overrun", bus.o_OVERRUN, 0);
        check("rst_busy", bus.o_BUSY, 0);
        @(negedge mclk);
        rst = 1'b0;

        // Default unity gains
        xs = '{1000, 0, 0, 0};
        frame("t1_unity", 0, 0, -1, 0, 0, 0);

        // Gains, mid-frame write and coincident write
        write_gain(1, 0, 8'h80);
        write_gain(1, 1, 8'h20);
        xs = '{0, -600, 0, 0};
        frame("t2_gain", 0, 0, 2, 1, 0, 8'h10);
        frame("t2_next", 0, 0, -1, 0, 0, 0);
        frame("t2_coinc", 0, 0, 0, 1, 1, 8'h40);
        frame("t2_after", 0, 0, -1, 0, 0, 0);

        // Saturation both directions
        write_gain(0, 0, 8'h80);
        write_gain(1, 0, 8'h80);
        xs = '{20000, 20000, 0, 0};
        frame("t3_pos", 0, 0, -1, 0, 0, 0);
        xs = '{-20000, -20000, 0, 0};
        frame("t3_neg", 0, 0, -1, 0, 0, 0);

        // Overrun: strobe 2 cycles in, and strobe during the VALID cycle
        xs = '{1234, -4321, 777, -32768};
        frame("t4_overrun", 2, 0, -1, 0, 0, 0);
        xs = '{-5, 32767, 100, 9};
        frame("t4_out_strobe", 0, 1, -1, 0, 0, 0);

        // Reset during MAC cycle 2
        @(negedge mclk);
        bus.i_SAMPLE_CEN = 1'b1;
        @(posedge mclk); #1;
        bus.i_SAMPLE_CEN = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("t5_busy", bus.o_BUSY, 0);
        check("t5_valid", bus.o_SAMPLE_VALID, 0);
        check("t5_snd_l", $signed(bus.o_SND_L), 0);
        @(negedge mclk);
        rst = 1'b0;
        nvalid = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            @(posedge mclk); #1;
            if (bus.o_SAMPLE_VALID) nvalid++;
        end
        check("t5_no_valid", nvalid, 0);
        xs = '{3000, -2000, 1500, -700};
        frame("t5_after", 0, 0, -1, 0, 0, 0);

        // Randomized frames with random gain updates
        for (int it = 0; it < 24; it++) begin
            repeat ($urandom_range(2))
                write_gain(int'($urandom_range(NCH - 1)), int'($urandom_range(1)),
                           int'($urandom_range(255)));
            for (int ch = 0; ch < NCH; ch++)
                xs[ch] = int'($urandom_range(65535)) - 32768;
            frame("rnd", 0, 0, -1, 0, 0, 0);
        end

`ifdef SND_MIXER_DCBLOCK_EN
        // Constant input through the DC blocker from a clean reset
        @(negedge mclk);
        rst = 1'b1;
        model_reset();
        @(negedge mclk);
        rst = 1'b0;
        xs = '{1000, 0, 0, 0};
        for (int it = 0; it < 40; it++)
            frame("dc_const", 0, 0, -1, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
